tx_sense_gate: RTL and testbench

//  Transmit-side consumer of the spectrum-sensing comparator decision (comp_in: 1 = channel

---
 rtl/tx_sense_gate.sv | 121 ++++++++++++
 tb/tb_tx_sense_gate.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/tx_sense_gate.sv
// TX gate driven by the spectrum-sensing comparator. The channel must read clear for
// CLEAR_CNT consecutive cycles before samples may pass. A busy decision while
// transmitting forces a fixed holdoff before the channel is sensed again.
module tx_sense_gate #(
  parameter int unsigned DWIDTH    = 32,
  parameter int unsigned CLEAR_CNT = 16,
  parameter int unsigned HOLDOFF   = 64,
  parameter int unsigned CW        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_tx,
  input  logic              comp_in,
  input  logic              threshold_changed,
  input  logic [DWIDTH-1:0] i_tdata,
  input  logic              i_tvalid,
  output logic              i_tready,
  output logic [DWIDTH-1:0] o_tdata,
  output logic              o_tvalid,
  input  logic              o_tready,
  output logic              tx_active,
  output logic [15:0]       busy_events,
  output logic [31:0]       tx_beats
);

  typedef enum logic [1:0] {StIdle, StSense, StTx, StHoldoff} state_e;

  localparam logic [CW-1:0] ClrLast  = CW'(CLEAR_CNT - 1);
  localparam logic [CW-1:0] HoldLast = CW'(HOLDOFF - 1);

  state_e            state_q;
  logic              comp_q;
  logic [CW-1:0]     clr_cnt_q;
  logic [CW-1:0]     hold_cnt_q;
  logic [15:0]       busy_events_q;
  logic [31:0]       tx_beats_q;
  logic [DWIDTH-1:0] o_tdata_q;
  logic              o_tvalid_q;
  logic              beat_acc;

  assign tx_active   = (state_q == StTx);
  // The output register may refill in the same cycle it drains.
  assign i_tready    = (state_q == StTx) & (~o_tvalid_q | o_tready);
  assign beat_acc    = i_tvalid & i_tready;
  assign o_tdata     = o_tdata_q;
  assign o_tvalid    = o_tvalid_q;
  assign busy_events = busy_events_q;
  assign tx_beats    = tx_beats_q;

  // Channel qualification FSM: priority is run_tx, then threshold_changed, then comp_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      comp_q        <= 1'b1;
      clr_cnt_q     <= '0;
      hold_cnt_q    <= '0;
      busy_events_q <= '0;
    end else begin
      comp_q <= comp_in;
      if (!run_tx) begin
        state_q    <= StIdle;
        clr_cnt_q  <= '0;
        hold_cnt_q <= '0;
      end else begin
        case (state_q)
          StIdle: begin
            state_q   <= StSense;
            clr_cnt_q <= '0;
          end
          StSense: begin
            if (threshold_changed || comp_q) begin
              clr_cnt_q <= '0;
            end else if (clr_cnt_q == ClrLast) begin
              state_q   <= StTx;
              clr_cnt_q <= '0;
            end else begin
              clr_cnt_q <= clr_cnt_q + CW'(1);
            end
          end
          StTx: begin
            if (threshold_changed) begin
              state_q   <= StSense;
              clr_cnt_q <= '0;
            end else if (comp_q) begin
              state_q    <= StHoldoff;
              hold_cnt_q <= '0;
              if (busy_events_q != 16'hFFFF) busy_events_q <= busy_events_q + 16'd1;
            end
          end
          StHoldoff: begin
            // Holdoff length is fixed; comparator and threshold changes are ignored here.
            if (hold_cnt_q == HoldLast) begin
              state_q    <= StSense;
              clr_cnt_q  <= '0;
              hold_cnt_q <= '0;
            end else begin
              hold_cnt_q <= hold_cnt_q + CW'(1);
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // Single output register stage; a held beat drains regardless of FSM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_tdata_q  <= '0;
      o_tvalid_q <= 1'b0;
      tx_beats_q <= '0;
    end else if (beat_acc) begin
      o_tdata_q  <= i_tdata;
      o_tvalid_q <= 1'b1;
      tx_beats_q <= tx_beats_q + 32'd1;
    end else if (o_tready) begin
      o_tvalid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tx_sense_gate.sv
// Directed bench for tx_sense_gate with a data scoreboard: accepted beats are queued by a
// source process and compared in order by an output monitor.
module tb_tx_sense_gate;

  logic        clk = 1'b0;
  logic        rst;
  logic        run_tx;
  logic        comp_in;
  logic        threshold_changed;
  logic [31:0] i_tdata;
  logic        i_tvalid;
  logic        i_tready;
  logic [31:0] o_tdata;
  logic        o_tvalid;
  logic        o_tready;
  logic        tx_active;
  logic [15:0] busy_events;
  logic [31:0] tx_beats;

  int checks   = 0;
  int failures = 0;
  int mon_cnt  = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  tx_sense_gate #(
    .DWIDTH   (32),
    .CLEAR_CNT(16),
    .HOLDOFF  (64),
    .CW       (16)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .run_tx           (run_tx),
    .comp_in          (comp_in),
    .threshold_changed(threshold_changed),
    .i_tdata          (i_tdata),
    .i_tvalid         (i_tvalid),
    .i_tready         (i_tready),
    .o_tdata          (o_tdata),
    .o_tvalid         (o_tvalid),
    .o_tready         (o_tready),
    .tx_active        (tx_active),
    .busy_events      (busy_events),
    .tx_beats         (tx_beats)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Source: queue each beat that will be accepted at the next edge, then advance the pattern.
  initial begin
    i_tdata = 32'h0001_0001;
    forever begin
      @(negedge clk);
      if (!rst && i_tvalid && i_tready) begin
        exp_q.push_back(i_tdata);
        @(posedge clk);
        #1;
        i_tdata = i_tdata + 32'h0001_0001;
      end
    end
  end

  // Monitor: every output transfer must match the oldest queued beat.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && o_tvalid && o_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out_unexpected: got %h expected no beat", o_tdata);
        end else begin
          chk("out_data", o_tdata, exp_q.pop_front());
        end
        mon_cnt++;
      end
    end
  end

  initial begin
    rst = 1'b1;
    run_tx = 1'b0;
    comp_in = 1'b1;
    threshold_changed = 1'b0;
    i_tvalid = 1'b0;
    o_tready = 1'b0;
    repeat (3) cyc();
    chk("rst_tx_active", 32'(tx_active), 32'd0);
    chk("rst_i_tready", 32'(i_tready), 32'd0);
    chk("rst_o_tvalid", 32'(o_tvalid), 32'd0);
    chk("rst_o_tdata", o_tdata, 32'd0);
    chk("rst_busy", 32'(busy_events), 32'd0);
    chk("rst_beats", tx_beats, 32'd0);

    // Clear channel from the first cycle: TX granted after 17 edges.
    rst = 1'b0;
    run_tx = 1'b1;
    comp_in = 1'b0;
    i_tvalid = 1'b1;
    o_tready = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      cyc();
      chk("t1_tx_active", 32'(tx_active), 32'(n == 17));
      chk("t1_i_tready", 32'(i_tready), 32'(n == 17));
    end
    repeat (8) cyc();
    chk("t1_beats", tx_beats, 32'd8);

    // Busy while streaming: one more beat passes alongside the FSM decision, then holdoff.
    comp_in = 1'b1;
    cyc();
    cyc();
    chk("t3_tx_active", 32'(tx_active), 32'd0);
    chk("t3_i_tready", 32'(i_tready), 32'd0);
    chk("t3_busy", 32'(busy_events), 32'd1);
    chk("t3_beats", tx_beats, 32'd10);
    comp_in = 1'b0;
    // 63 more holdoff cycles, then 16 clear cycles in SENSE.
    for (int n = 1; n <= 80; n++) begin
      cyc();
      chk("t3_holdoff_active", 32'(tx_active), 32'(n == 80));
    end

    // Backpressure when leaving TX: held beat must stay intact until drained.
    cyc();
    chk("t4_beats_pre", tx_beats, 32'd11);
    o_tready = 1'b0;
    comp_in = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      cyc();
      chk("t4_o_tvalid_held", 32'(o_tvalid), 32'd1);
      chk("t4_o_tdata_held", o_tdata, 32'h000B_000B);
    end
    chk("t4_busy", 32'(busy_events), 32'd2);
    chk("t4_tx_active", 32'(tx_active), 32'd0);
    o_tready = 1'b1;
    cyc();
    chk("t4_o_tvalid_drained", 32'(o_tvalid), 32'd0);
    chk("t4_mon_cnt", 32'(mon_cnt), 32'd11);
    chk("t4_beats", tx_beats, 32'd11);

    // run_tx drop in HOLDOFF goes straight to IDLE; requalification starts from scratch.
    cyc();
    run_tx = 1'b0;
    cyc();
    run_tx = 1'b1;
    comp_in = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      cyc();
      chk("t6_idle_requal", 32'(tx_active), 32'(k == 17));
    end

    // Threshold change in TX: back to SENSE without counting a busy event.
    repeat (4) cyc();
    chk("t5_beats_pre", tx_beats, 32'd15);
    threshold_changed = 1'b1;
    cyc();
    threshold_changed = 1'b0;
    chk("t5_tx_active", 32'(tx_active), 32'd0);
    chk("t5_busy", 32'(busy_events), 32'd2);
    chk("t5_beats", tx_beats, 32'd16);
    for (int k = 1; k <= 16; k++) begin
      cyc();
      chk("t5_requal", 32'(tx_active), 32'(k == 16));
    end

    // Busy pulse every 10th cycle keeps SENSE from ever granting TX.
    run_tx = 1'b0;
    cyc();
    run_tx = 1'b1;
    for (int n = 0; n < 60; n++) begin
      comp_in = (n % 10 == 9);
      cyc();
      chk("t2_no_tx", 32'(tx_active), 32'd0);
    end
    comp_in = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      cyc();
      chk("t2_requal", 32'(tx_active), 32'(k == 16));
    end

    // Reset mid-burst discards the held beat.
    repeat (3) cyc();
    chk("t6_queue_pre", 32'(exp_q.size()), 32'd1);
    rst = 1'b1;
    cyc();
    exp_q.delete();
    chk("t6_rst_tx_active", 32'(tx_active), 32'd0);
    chk("t6_rst_i_tready", 32'(i_tready), 32'd0);
    chk("t6_rst_o_tvalid", 32'(o_tvalid), 32'd0);
    chk("t6_rst_o_tdata", o_tdata, 32'd0);
    chk("t6_rst_busy", 32'(busy_events), 32'd0);
    chk("t6_rst_beats", tx_beats, 32'd0);
    rst = 1'b0;
    run_tx = 1'b0;
    i_tvalid = 1'b0;
    repeat (3) cyc();
    chk("end_o_tvalid", 32'(o_tvalid), 32'd0);
    chk("end_queue", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
